// File: rtl/conv_pkg.sv
// Shared constants, derived geometry and FSM state encoding for the 3x3
// convolution window sequencer.
package conv_pkg;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;

    // Valid-window output geometry
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;

    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int OIDX_W = $clog2(OUT_W * OUT_H);

    // Kernel coefficient index 0..K*K-1
    localparam int TAP_W  = 4;

    // Coordinate counters carry one spare bit so the row counter can step
    // one past the last output row on the final handshake without wrapping.
    localparam int CNT_W  = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_RESULT = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

endpackage

// File: rtl/conv_win_addr_gen.sv
// Nested kx/ky/col/row counters for the window walk. Produces the RAM read
// address, kernel tap index and output pixel index combinationally from the
// current counter values, plus end-of-window / end-of-frame flags.
module conv_win_addr_gen
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,     // zero all counters (wins over steps)
    input  logic              step_tap,  // advance kx, then ky
    input  logic              step_win,  // advance col, then row
    output logic [ADDR_W-1:0] addr,
    output logic [TAP_W-1:0]  tap_idx,
    output logic [OIDX_W-1:0] res_idx,
    output logic              tap_end,   // current tap is (K-1, K-1)
    output logic              win_end    // current window is the last one
);

    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(OUT_H - 1);

    logic [CNT_W-1:0] kx_q,  kx_d;
    logic [CNT_W-1:0] ky_q,  ky_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    logic [ADDR_W-1:0] y_pos;
    logic [ADDR_W-1:0] x_pos;

    // Counter next-state: kernel taps wrap back to (0,0) after the last tap
    always_comb begin
        kx_d  = kx_q;
        ky_d  = ky_q;
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            kx_d  = '0;
            ky_d  = '0;
            col_d = '0;
            row_d = '0;
        end else begin
            if (step_tap) begin
                if (kx_q == K_LAST) begin
                    kx_d = '0;
                    ky_d = (ky_q == K_LAST) ? '0 : ky_q + 1'b1;
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            if (step_win) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_q  <= '0;
            ky_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            kx_q  <= kx_d;
            ky_q  <= ky_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Address / index arithmetic in unsigned ADDR_W / OIDX_W widths
    always_comb begin
        y_pos   = ADDR_W'(row_q) + ADDR_W'(ky_q);
        x_pos   = ADDR_W'(col_q) + ADDR_W'(kx_q);
        addr    = y_pos * ADDR_W'(IMG_W) + x_pos;
        tap_idx = TAP_W'(ky_q) * TAP_W'(K) + TAP_W'(kx_q);
        res_idx = OIDX_W'(row_q) * OIDX_W'(OUT_W) + OIDX_W'(col_q);
        tap_end = (kx_q == K_LAST) && (ky_q == K_LAST);
        win_end = (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame-level controller for the 3x3 convolution datapath: walks every valid
// window in raster order, issues the K*K RAM reads, tags the returning taps
// (one-cycle RAM latency) for the MAC, then holds the result until accepted.
module conv_window_sequencer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              tap_valid,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              tap_first,
    output logic              tap_last,
    output logic              res_valid,
    output logic [OIDX_W-1:0] res_idx,
    input  logic              res_ready
);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(K * K - 1);

    state_e state_q, state_d;

    logic              cnt_clear;
    logic              cnt_step_tap;
    logic              cnt_step_win;
    logic [ADDR_W-1:0] gen_addr;
    logic [TAP_W-1:0]  gen_tap_idx;
    logic [OIDX_W-1:0] gen_res_idx;
    logic              gen_tap_end;
    logic              gen_win_end;

    logic              tap_valid_q;
    logic [TAP_W-1:0]  tap_idx_q;
    logic              tap_first_q;
    logic              tap_last_q;

    conv_win_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .step_tap (cnt_step_tap),
        .step_win (cnt_step_win),
        .addr     (gen_addr),
        .tap_idx  (gen_tap_idx),
        .res_idx  (gen_res_idx),
        .tap_end  (gen_tap_end),
        .win_end  (gen_win_end)
    );

    // Next-state and counter control; abort overrides everything, including start
    always_comb begin
        state_d      = state_q;
        cnt_clear    = 1'b0;
        cnt_step_tap = 1'b0;
        cnt_step_win = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_ISSUE;
                        cnt_clear = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_step_tap = 1'b1;
                    if (gen_tap_end) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        cnt_step_win = 1'b1;
                        state_d      = gen_win_end ? ST_FIN : ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tap tag pipeline: issue-cycle tags delayed to line up with RAM data;
    // abort kills any tap still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
        end else if (abort || (state_q != ST_ISSUE)) begin
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
        end else begin
            tap_valid_q <= 1'b1;
            tap_idx_q   <= gen_tap_idx;
            tap_first_q <= (gen_tap_idx == '0);
            tap_last_q  <= (gen_tap_idx == TAP_LAST);
        end
    end

    // Outputs decoded from the registered state; address/index zeroed when idle
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        ram_rd_en = (state_q == ST_ISSUE);
        ram_addr  = ram_rd_en ? gen_addr : '0;
        res_valid = (state_q == ST_RESULT);
        res_idx   = res_valid ? gen_res_idx : '0;
        tap_valid = tap_valid_q;
        tap_idx   = tap_idx_q;
        tap_first = tap_first_q;
        tap_last  = tap_last_q;
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: full frames, result stall,
// abort, asynchronous reset mid-result and ignored start conditions.
module tb_conv_window_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       ram_rd_en;
    logic [5:0] ram_addr;
    logic       tap_valid;
    logic [3:0] tap_idx;
    logic       tap_first;
    logic       tap_last;
    logic       res_valid;
    logic [5:0] res_idx;
    logic       res_ready;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cnt  = 0;

    logic [22:0] outvec;
    assign outvec = {busy, done, ram_rd_en, ram_addr, tap_valid, tap_idx,
                     tap_first, tap_last, res_valid, res_idx};

    conv_window_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .tap_valid (tap_valid),
        .tap_idx   (tap_idx),
        .tap_first (tap_first),
        .tap_last  (tap_last),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    // One window with res_ready high except for 'stall' RESULT cycles.
    // Entered right after the edge into ISSUE; leaves right after the handshake edge.
    task automatic run_window(input int w, input int stall);
        int offs [9];
        int base;
        offs = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        base = (w / 6) * 8 + (w % 6);
        res_ready = (stall == 0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("w%0d_rd_en_%0d", w, i), 32'(ram_rd_en), 32'd1);
            chk($sformatf("w%0d_addr_%0d", w, i), 32'(ram_addr), base + offs[i]);
            chk($sformatf("w%0d_tvalid_%0d", w, i), 32'(tap_valid), 32'(i != 0));
            if (i != 0) chk($sformatf("w%0d_tidx_%0d", w, i), 32'(tap_idx), i - 1);
            chk($sformatf("w%0d_tfirst_%0d", w, i), 32'(tap_first), 32'(i == 1));
            chk($sformatf("w%0d_tlast_%0d", w, i), 32'(tap_last), 32'd0);
            chk($sformatf("w%0d_resv_%0d", w, i), 32'(res_valid), 32'd0);
            tick();
        end
        // drain cycle: last tap on the bus, no read
        chk($sformatf("w%0d_drain", w), {23'd0, ram_rd_en, tap_valid, tap_idx, tap_first, tap_last, res_valid},
            {23'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0});
        tick();
        for (int s = 0; s < stall; s++) begin
            chk($sformatf("w%0d_stall_%0d", w, s), {23'd0, ram_rd_en, tap_valid, res_valid, res_idx, done},
                {23'd0, 1'b0, 1'b0, 1'b1, 6'(w), 1'b0});
            tick();
        end
        res_ready = 1'b1;
        chk($sformatf("w%0d_result", w), {23'd0, ram_rd_en, tap_valid, res_valid, res_idx, done},
            {23'd0, 1'b0, 1'b0, 1'b1, 6'(w), 1'b0});
        tick();
    endtask

    task automatic check_fin(input int extra);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_latency", cyc - start_cyc, 396 + extra);
        chk("fin_no_result", 32'(res_valid), 32'd0);
        tick();
        chk("idle_after_fin", 32'(outvec), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'(outvec), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 32'(outvec), 32'd0);

        // Frame A: full frame, res_ready high
        res_ready = 1'b1;
        start_frame();
        for (int w = 0; w < 36; w++) run_window(w, 0);
        check_fin(0);
        chk("done_count_a", done_cnt, 1);

        // Frame B: start held during window 3, 5-cycle stall on result 7
        start_frame();
        for (int w = 0; w < 36; w++) begin
            start = (w == 3);
            run_window(w, (w == 7) ? 5 : 0);
        end
        start = 1'b0;
        check_fin(5);
        chk("done_count_b", done_cnt, 2);

        // Frame C: abort during ISSUE of window 3
        start_frame();
        for (int w = 0; w < 3; w++) run_window(w, 0);
        chk("abort_w3_addr0", 32'(ram_addr), 32'd3);
        tick();
        chk("abort_w3_addr1", 32'(ram_addr), 32'd4);
        tick();
        chk("abort_w3_addr2", 32'(ram_addr), 32'd5);
        tick();
        chk("abort_w3_addr3", 32'(ram_addr), 32'd11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_to_idle", 32'(outvec), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("abort_quiet_%0d", i), 32'(outvec), 32'd0);
        end
        chk("done_count_abort", done_cnt, 2);

        // Restart after abort begins at address 0; reset hits during result 2
        start_frame();
        run_window(0, 0);
        run_window(1, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_result", {26'd0, res_valid, res_idx}, {26'd0, 1'b1, 6'd2});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(outvec), 32'd0);
        tick();
        chk("reset_held_outputs", 32'(outvec), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("after_reset_idle", 32'(outvec), 32'd0);
        chk("done_count_reset", done_cnt, 2);

        // Frame D: clean full frame after reset
        start_frame();
        for (int w = 0; w < 36; w++) run_window(w, 0);
        check_fin(0);
        chk("done_count_d", done_cnt, 3);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(outvec), 32'd0);
        tick();
        chk("start_abort_still_idle", 32'(outvec), 32'd0);
        chk("done_count_final", done_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
